read_capture_fifo: RTL and testbench
====================================

READ_CAPTURE_FIFO -- requirements
Module: read_capture_fifo

Interface
REQ-001 Parameter DW, default 8: width of read data word.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-003 Parameter CW, default 4: width of wait-cycle count field.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 rd  in  1  read strobe from the upstream read controller; high during each read cycle.
REQ-007 ds  in  1  done strobe from the upstream controller; one cycle per completed read transaction.
REQ-008 rdata  in  DW  read data bus; sampled on every rd cycle.
REQ-009 out_valid  out  1  FIFO head holds a valid record.
REQ-010 out_ready  in  1  consumer accepts the head record.
REQ-011 out_data  out  DW  head record data.
REQ-012 out_cycles  out  CW  head record rd-cycle count.
REQ-013 full  out  1  FIFO full; the upstream gates its go request with this.
REQ-014 ovf  out  1  sticky: a record was dropped because the FIFO was full.
REQ-015 perr  out  1  sticky: ds seen without a preceding rd run.

Function
REQ-016 Capture FSM shall have states IDLE and ACTIVE, one-hot encoded, with an all-X default used for unreachable codes.
REQ-017 IDLE->ACTIVE on rd=1 and ds=0; ACTIVE->IDLE on ds=1; otherwise hold state.
REQ-018 Every cycle with rd=1 shall load hold register <= rdata and increment the cycle counter, saturating at 2^CW-1.
REQ-019 Entering ACTIVE from IDLE shall load the counter with 1, discarding any prior count.
REQ-020 ds=1 in ACTIVE shall push {hold, count} into the FIFO; if rd=1 in the same cycle, the pushed record shall use this cycle's rdata and count+1 (saturated).
REQ-021 ds=1 in IDLE with rd=0 shall push nothing and set perr; ds=1 with rd=1 in IDLE shall push {rdata, 1}.
REQ-022 A pushed record shall appear at the head (out_valid=1) the cycle after the ds edge when the FIFO was empty: one-cycle latency.
REQ-023 Pop occurs when out_valid=1 and out_ready=1; the head advances on that edge.
REQ-024 Push when full shall be accepted only if a pop occurs in the same cycle; otherwise the record is dropped and ovf is set.
REQ-025 Simultaneous push and pop when empty: the push is stored, there is no pop, and out_valid=1 on the next cycle.
REQ-026 Pointers shall be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty shall be derived from the MSB and index compare.
REQ-027 When out_valid=0, out_data and out_cycles shall read 0.
REQ-028 rd=1 while already ACTIVE shall not restart the counter; wait-state loops accumulate.

Reset
REQ-029 On rstn low: state=IDLE, pointers=0, hold=0, counter=0, out_valid=0, out_data=0, out_cycles=0, full=0, ovf=0, perr=0.
REQ-030 Reset mid-transaction shall discard the partial capture and all queued records; no push occurs on the first edge after reset release unless ds=1 with rd=1.

Configuration
REQ-031 With macro RDCAP_STATS_EN defined, the counter and the count storage field shall be built and out_cycles shall behave as above.
REQ-032 Without RDCAP_STATS_EN, the counter and count field shall be omitted, FIFO width shall be DW, and out_cycles shall be tied to 0.

Structure
REQ-033 Package rdcap_pkg shall hold the capture state enum and the record struct {data, cycles}, with widths derived from parameters via localparams.
REQ-034 Storage shall be sub-module rdcap_fifo: a synchronous FIFO with push/pop/full/empty; the FSM, hold register and counter shall stay in the top level.

Verification
REQ-035 Single read, rd=1 for 2 cycles with rdata=0x11 then 0x5A, ds=1 next cycle -> out_valid=1 one cycle later, out_data=0x5A, out_cycles=2.
REQ-036 Wait-state loop, rd held for 6 cycles (last rdata=0xC3), then ds -> out_data=0xC3, out_cycles=6; with 20 rd cycles -> out_cycles=15 (saturated).
REQ-037 out_ready=0, 5 transactions with DEPTH=4 -> full=1 after the 4th, 5th dropped, ovf=1; popping returns the first 4 records in order.
REQ-038 FIFO full and out_ready=1 on the cycle ds arrives -> the record is accepted, full stays 1, ovf stays 0.
REQ-039 ds pulse with no prior rd -> perr=1 and out_valid stays 0; rstn asserted mid-ACTIVE -> all outputs 0, and the next transaction captures cleanly.

Source files
------------

// File: rtl/rdcap_pkg.sv
// Shared types for the read-capture FIFO: capture FSM state and the queued record layout.
package rdcap_pkg;

  localparam int unsigned RDCAP_DW = 8;
  localparam int unsigned RDCAP_CW = 4;

  // One-hot capture states
  typedef enum logic [1:0] {
    StIdle   = 2'b01,
    StActive = 2'b10
  } rdcap_state_e;

  typedef struct packed {
    logic [RDCAP_DW-1:0] data;
    logic [RDCAP_CW-1:0] cycles;
  } rdcap_rec_t;

endpackage

// File: rtl/rdcap_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is taken only alongside a pop.
module rdcap_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  r_wptr, r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_wr, w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/read_capture_fifo.sv
// Captures read data and rd-cycle counts per transaction into a FIFO.
// Optional cycle statistics enabled by defining RDCAP_STATS_EN.
module read_capture_fifo
  import rdcap_pkg::*;
#(
  parameter int unsigned DW    = RDCAP_DW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = RDCAP_CW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rd,
  input  logic          ds,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_cycles,
  output logic          full,
  output logic          ovf,
  output logic          perr
);

  rdcap_state_e  r_state;
  logic [DW-1:0] r_hold;
  logic          r_ovf, r_perr;
  logic          w_push, w_pop, w_full, w_empty;
  logic [DW-1:0] w_push_data;

  assign out_valid   = ~w_empty;
  assign full        = w_full;
  assign ovf         = r_ovf;
  assign perr        = r_perr;
  assign w_pop       = out_valid & out_ready;
  // A ds in IDLE only pushes when it coincides with a single-cycle read
  assign w_push      = ds & ((r_state == StActive) | rd);
  assign w_push_data = rd ? rdata : r_hold;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_hold  <= '0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (rd) r_hold <= rdata;
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (rd & ~ds) r_state <= StActive;
          if (ds & ~rd) r_perr <= 1'b1;
        end
        StActive: if (ds) r_state <= StIdle;
        default:  r_state <= rdcap_state_e'('x);
      endcase
    end
  end

`ifdef RDCAP_STATS_EN
  localparam int unsigned RecW = DW + CW;

  logic [CW-1:0]   r_cnt, w_cnt_inc, w_push_cnt;
  logic [RecW-1:0] w_wdata, w_rdata;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  // A same-cycle rd folds into the pushed record
  assign w_push_cnt = (r_state == StActive) ? (rd ? w_cnt_inc : r_cnt) : CW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (rd) begin
      r_cnt <= (r_state == StActive) ? w_cnt_inc : CW'(1);
    end
  end

  assign w_wdata    = {w_push_data, w_push_cnt};
  assign out_data   = out_valid ? w_rdata[RecW-1:CW] : '0;
  assign out_cycles = out_valid ? w_rdata[CW-1:0] : '0;
`else
  localparam int unsigned RecW = DW;

  logic [RecW-1:0] w_wdata, w_rdata;

  assign w_wdata    = w_push_data;
  assign out_data   = out_valid ? w_rdata : '0;
  assign out_cycles = '0;
`endif

  rdcap_fifo #(
    .W     (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_read_capture_fifo.sv
// Directed bench for read_capture_fifo: vector table plus hand sequences for multi-cycle cases.
module tb_read_capture_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;
`ifdef RDCAP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, rd, ds, out_ready;
  logic [DW-1:0] rdata;
  logic          out_valid, full, ovf, perr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  read_capture_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rd         (rd),
    .ds         (ds),
    .rdata      (rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cycles (out_cycles),
    .full       (full),
    .ovf        (ovf),
    .perr       (perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       ds;
    logic [7:0] rdata;
    logic       rdy;
    logic       v;
    logic [7:0] d;
    int         c;
    logic       f;
    logic       o;
    logic       p;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [CW-1:0] ec(int n);
    return STATS ? CW'(n) : '0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic i_rd, logic i_ds, logic [7:0] i_d, logic i_rdy);
    rd = i_rd; ds = i_ds; rdata = i_d; out_ready = i_rdy;
  endtask

  task automatic check_outs(string tag, logic v, logic [7:0] d, logic [CW-1:0] c,
                            logic f, logic o, logic p);
    check({tag, ".valid"},  32'(out_valid),  32'(v));
    check({tag, ".data"},   32'(out_data),   32'(d));
    check({tag, ".cycles"}, 32'(out_cycles), 32'(c));
    check({tag, ".full"},   32'(full),       32'(f));
    check({tag, ".ovf"},    32'(ovf),        32'(o));
    check({tag, ".perr"},   32'(perr),       32'(p));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // One rd cycle followed by ds; leaves inputs idle
  task automatic txn(logic [7:0] d, logic rdy_on_ds);
    drive(1'b1, 1'b0, d, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h00, rdy_on_ds);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    //            rd ds rdata  rdy  v  d      c  f  o  p
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h5A, 2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hC3, 6, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 8'h77, 1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};

    // Reset state
    rstn = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check_outs("reset", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
    step();
    rstn = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rd, tbl[i].ds, tbl[i].rdata, tbl[i].rdy);
      step();
      check_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, ec(tbl[i].c),
                 tbl[i].f, tbl[i].o, tbl[i].p);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Counter saturation over a 20-cycle wait-state loop
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("sat.valid",  32'(out_valid),  32'd1);
    check("sat.data",   32'(out_data),   32'h14);
    check("sat.cycles", 32'(out_cycles), 32'(ec(15)));
    pop_one();
    check("sat.drained", 32'(out_valid), 32'd0);

    // Overflow: five transactions with consumer stalled
    do_reset();
    for (int k = 0; k < 5; k++) begin
      txn(8'(8'h20 + k), 1'b0);
      check($sformatf("ovf.full%0d", k), 32'(full), 32'(k >= 3));
      check($sformatf("ovf.ovf%0d", k),  32'(ovf),  32'(k == 4));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ovf.v%0d", k), 32'(out_valid),  32'd1);
      check($sformatf("ovf.d%0d", k), 32'(out_data),   32'(8'h20 + k));
      check($sformatf("ovf.c%0d", k), 32'(out_cycles), 32'(ec(1)));
      pop_one();
    end
    check("ovf.empty", 32'(out_valid), 32'd0);
    check("ovf.notfull", 32'(full), 32'd0);

    // Push while full with a same-cycle pop is accepted
    do_reset();
    check("full_pop.ovf_cleared", 32'(ovf), 32'd0);
    for (int k = 0; k < 4; k++) txn(8'(8'h40 + k), 1'b0);
    check("full_pop.full_before", 32'(full), 32'd1);
    txn(8'h44, 1'b1);
    check("full_pop.full_after", 32'(full), 32'd1);
    check("full_pop.ovf", 32'(ovf), 32'd0);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("full_pop.d%0d", k), 32'(out_data), 32'(8'h40 + k));
      pop_one();
    end
    check("full_pop.empty", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-transaction with a record queued
    txn(8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'h66, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'h67, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check_outs("midrst", 1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    rstn = 1'b1;
    step();
    check("postrst.valid", 32'(out_valid), 32'd0);
    drive(1'b1, 1'b0, 8'h3C, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'h3D, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_outs("postrst", 1'b1, 8'h3D, ec(2), 1'b0, 1'b0, 1'b0);
    pop_one();
    check("postrst.empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
